stream_fifo_param: RTL and testbench

- Parametrised successor to the fixed-size single-clock stream FIFO that links CPU-side Xillybus streams and HLS processes on bus_clk.
- Keeps the same handshake semantics: if_write/if_full_n on the write side, if_read/if_empty_n on the read side.
- Adds configurable width and depth, a first-word-fall-through (FWFT) or standard read mode, an occupancy count, almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow flags.
- Instantiated between producer/consumer pairs: ARM→process, process→process, process→ARM.

---
 rtl/stream_fifo_pkg.sv | 22 ++
 rtl/stream_fifo_ram.sv | 56 +++++
 rtl/stream_fifo_param.sv | 153 +++++++++++++++
 tb/tb_stream_fifo_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the parametrised stream FIFO.
package stream_fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2. Passing DEPTH+1 gives the bit width needed to hold
  // an occupancy of 0..DEPTH.
  function automatic int fifo_clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage array: one write port, one read port.
// In FWFT mode the read is asynchronous so the head word is visible at
// once. In standard mode the read is registered, with an enable, so the
// array maps onto block RAM with its output register.
import stream_fifo_pkg::*;

module stream_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = FIFO_MODE_FWFT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never cleared so the array stays a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_read
      // The read enable and reset have no role with an asynchronous read.
      logic unused_ctrl;
      assign unused_ctrl = rst_n ^ rd_en;
      assign rd_data     = mem[rd_addr];
    end else begin : g_std_read
      logic [DATA_WIDTH-1:0] rd_data_reg;

      // Registered read: the word appears the cycle after the enable and
      // holds until the next enabled read.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_reg <= '0;
        end else if (rd_en) begin
          rd_data_reg <= mem[rd_addr];
        end
      end

      assign rd_data = rd_data_reg;
    end
  endgenerate

endmodule

// File: rtl/stream_fifo_param.sv
// Parametrised single-clock stream FIFO with if_write/if_full_n and
// if_read/if_empty_n handshakes, occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow indications.
import stream_fifo_pkg::*;

module stream_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = FIFO_MODE_FWFT,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  flush,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = fifo_clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  // Threshold legality is reported while elaborating.
  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
      $error("stream_fifo_param: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
      $error("stream_fifo_param: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end
  endgenerate

  // Registered state.
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_n_reg;
  logic                  empty_n_reg;
  logic                  almost_full_reg;
  logic                  almost_empty_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  // Handshake qualification against this cycle's registered flags.
  logic wr_try, rd_try;
  logic wr_acc, rd_acc;
  logic ram_wr_en, ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign wr_try = if_write & if_write_ce;
  assign rd_try = if_read & if_read_ce;
  assign wr_acc = wr_try & full_n_reg;
  assign rd_acc = rd_try & empty_n_reg;

  // Reset and flush both drop any transfer requested in the same cycle.
  assign ram_wr_en = wr_acc & ap_rst_n & ~flush;
  assign ram_rd_en = rd_acc & ap_rst_n & ~flush;

  // Next pointer and occupancy values; a simultaneous read and write
  // leaves the count unchanged while both pointers advance.
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (wr_acc) begin
      wptr_next = wptr_reg + 1'b1;
    end
    if (rd_acc) begin
      rptr_next = rptr_reg + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // State register: reset wins over flush, flush wins over transfers.
  // Flags are computed from the next count so they settle one cycle
  // after the transfer that moved them.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || flush) begin
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      count_reg        <= '0;
      full_n_reg       <= 1'b1;
      empty_n_reg      <= 1'b0;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wptr_reg         <= wptr_next;
      rptr_reg         <= rptr_next;
      count_reg        <= count_next;
      full_n_reg       <= (count_next != DEPTH_CNT);
      empty_n_reg      <= (count_next != '0);
      almost_full_reg  <= (count_next >= AF_CNT);
      almost_empty_reg <= (count_next <= AE_CNT);
      overflow_reg     <= overflow_reg | (wr_try & ~full_n_reg);
      underflow_reg    <= underflow_reg | (rd_try & ~empty_n_reg);
    end
  end

  stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .wr_en   (ram_wr_en),
    .wr_addr (wptr_reg),
    .wr_data (if_din),
    .rd_en   (ram_rd_en),
    .rd_addr (rptr_reg),
    .rd_data (ram_rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft_out
      // Head word is shown only while data is available, so an empty
      // FIFO presents zero rather than a stale RAM word.
      assign if_dout = empty_n_reg ? ram_rd_data : '0;
    end else begin : g_std_out
      assign if_dout = ram_rd_data;
    end
  endgenerate

  assign if_full_n    = full_n_reg;
  assign if_empty_n   = empty_n_reg;
  assign usedw        = count_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_stream_fifo_param.sv
// Directed bench: an FWFT instance and a standard-mode instance share
// one stimulus stream; flags are checked on the FWFT instance and read
// data on whichever instance the step targets.
module tb_stream_fifo_param;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          write_ce;
  logic          write;
  logic [DW-1:0] din;
  logic          read_ce;
  logic          read;

  logic          f_full_n, f_empty_n, f_af, f_ae, f_ov, f_uf;
  logic [DW-1:0] f_dout;
  logic [AW:0]   f_usedw;
  logic          s_full_n, s_empty_n, s_af, s_ae, s_ov, s_uf;
  logic [DW-1:0] s_dout;
  logic [AW:0]   s_usedw;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  stream_fifo_param #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (1), .AF_LEVEL (3), .AE_LEVEL (1)
  ) dut_fwft (
    .ap_clk (clk), .ap_rst_n (rst_n), .flush (flush),
    .if_write_ce (write_ce), .if_write (write), .if_din (din), .if_full_n (f_full_n),
    .if_read_ce (read_ce), .if_read (read), .if_dout (f_dout), .if_empty_n (f_empty_n),
    .usedw (f_usedw), .almost_full (f_af), .almost_empty (f_ae),
    .overflow (f_ov), .underflow (f_uf)
  );

  stream_fifo_param #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (0), .AF_LEVEL (3), .AE_LEVEL (1)
  ) dut_std (
    .ap_clk (clk), .ap_rst_n (rst_n), .flush (flush),
    .if_write_ce (write_ce), .if_write (write), .if_din (din), .if_full_n (s_full_n),
    .if_read_ce (read_ce), .if_read (read), .if_dout (s_dout), .if_empty_n (s_empty_n),
    .usedw (s_usedw), .almost_full (s_af), .almost_empty (s_ae),
    .overflow (s_ov), .underflow (s_uf)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge with
  // the request lines dropped again.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic fl = 1'b0, input logic rn = 1'b1);
    write = w; din = d; read = r; flush = fl; rst_n = rn;
    @(posedge clk);
    #1;
    $display("txn w=%0b din=%h r=%0b flush=%0b rst_n=%0b -> usedw=%0d fdout=%h sdout=%h full_n=%0b empty_n=%0b ov=%0b uf=%0b",
             w, d, r, fl, rn, f_usedw, f_dout, s_dout, f_full_n, f_empty_n, f_ov, f_uf);
    write = 1'b0; read = 1'b0; flush = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; write_ce = 1'b1; write = 1'b0;
    din = '0; read_ce = 1'b1; read = 1'b0;
    #1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    check("rst_usedw", 32'(f_usedw), 0);
    check("rst_full_n", 32'(f_full_n), 1);
    check("rst_empty_n", 32'(f_empty_n), 0);
    check("rst_af", 32'(f_af), 0);
    check("rst_ae", 32'(f_ae), 1);
    check("rst_ov", 32'(f_ov), 0);
    check("rst_uf", 32'(f_uf), 0);
    check("rst_fdout", f_dout, 0);
    check("rst_sdout", s_dout, 0);

    // Requests with the side enables low are ignored entirely.
    write_ce = 1'b0; read_ce = 1'b0;
    cycle(1'b1, 32'hDEAD, 1'b1);
    write_ce = 1'b1; read_ce = 1'b1;
    check("ce_usedw", 32'(f_usedw), 0);
    check("ce_ov", 32'(f_ov), 0);
    check("ce_uf", 32'(f_uf), 0);

    // Fill to full, then overflow.
    cycle(1'b1, 32'hA0, 1'b0);
    check("f1_usedw", 32'(f_usedw), 1);
    check("f1_empty_n", 32'(f_empty_n), 1);
    check("f1_ae", 32'(f_ae), 1);
    check("f1_fdout", f_dout, 32'hA0);
    cycle(1'b1, 32'hA1, 1'b0);
    check("f2_usedw", 32'(f_usedw), 2);
    check("f2_ae", 32'(f_ae), 0);
    check("f2_af", 32'(f_af), 0);
    cycle(1'b1, 32'hA2, 1'b0);
    check("f3_usedw", 32'(f_usedw), 3);
    check("f3_af", 32'(f_af), 1);
    check("f3_full_n", 32'(f_full_n), 1);
    cycle(1'b1, 32'hA3, 1'b0);
    check("f4_usedw", 32'(f_usedw), 4);
    check("f4_full_n", 32'(f_full_n), 0);
    check("f4_s_full_n", 32'(s_full_n), 0);
    cycle(1'b1, 32'hA4, 1'b0);
    check("f5_usedw", 32'(f_usedw), 4);
    check("f5_ov", 32'(f_ov), 1);
    cycle(1'b0, '0, 1'b0);
    check("f5_ov_sticky", 32'(f_ov), 1);

    // Drain: FWFT shows the head before each read, standard mode shows
    // the word the cycle after the read.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd%0d_fdout", i), f_dout, 32'hA0 + 32'(i));
      check($sformatf("rd%0d_empty_n", i), 32'(f_empty_n), 1);
      cycle(1'b0, '0, 1'b1);
      check($sformatf("rd%0d_sdout", i), s_dout, 32'hA0 + 32'(i));
      check($sformatf("rd%0d_usedw", i), 32'(f_usedw), 32'(3 - i));
    end
    check("dr_empty_n", 32'(f_empty_n), 0);
    check("dr_ae", 32'(f_ae), 1);
    cycle(1'b0, '0, 1'b1);
    check("uf_set", 32'(f_uf), 1);
    check("uf_usedw", 32'(f_usedw), 0);
    check("uf_ae", 32'(f_ae), 1);
    check("uf_sdout_hold", s_dout, 32'hA3);

    // Standard-mode read latency and hold.
    cycle(1'b1, 32'h11, 1'b0);
    cycle(1'b1, 32'h22, 1'b0);
    check("lat_fdout_pre", f_dout, 32'h11);
    check("lat_sdout_pre", s_dout, 32'hA3);
    cycle(1'b0, '0, 1'b1);
    check("lat_sdout_t1", s_dout, 32'h11);
    check("lat_fdout_t1", f_dout, 32'h22);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("lat_sdout_hold", s_dout, 32'h11);
    cycle(1'b0, '0, 1'b1);
    check("lat_sdout_2", s_dout, 32'h22);
    check("lat_uf_sticky", 32'(s_uf), 1);

    // Flush at empty clears the sticky flags.
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("fl0_ov", 32'(f_ov), 0);
    check("fl0_uf", 32'(f_uf), 0);
    check("fl0_sdout_hold", s_dout, 32'h22);

    // Simultaneous read and write at count 2.
    cycle(1'b1, 32'hB0, 1'b0);
    cycle(1'b1, 32'hB1, 1'b0);
    check("rw2_fdout_pre", f_dout, 32'hB0);
    cycle(1'b1, 32'hB2, 1'b1);
    check("rw2_usedw", 32'(f_usedw), 2);
    check("rw2_sdout", s_dout, 32'hB0);
    check("rw2_fdout", f_dout, 32'hB1);
    cycle(1'b0, '0, 1'b1);
    check("rw2_sdout_b1", s_dout, 32'hB1);
    cycle(1'b0, '0, 1'b1);
    check("rw2_sdout_b2", s_dout, 32'hB2);
    check("rw2_empty_n", 32'(f_empty_n), 0);

    // Simultaneous read and write at full: only the read is taken.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0);
    check("rw4_full_n_pre", 32'(f_full_n), 0);
    cycle(1'b1, 32'hC4, 1'b1);
    check("rw4_usedw", 32'(f_usedw), 3);
    check("rw4_ov", 32'(f_ov), 1);
    check("rw4_full_n", 32'(f_full_n), 1);
    check("rw4_sdout", s_dout, 32'hC0);
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      check($sformatf("rw4_drain%0d", i), s_dout, 32'hC0 + 32'(i));
    end
    check("rw4_drained", 32'(f_usedw), 0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Wrap-around through 12 write/read pairs.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 32'h100 + 32'(i), 1'b0);
      check($sformatf("wr%0d_fdout", i), f_dout, 32'h100 + 32'(i));
      cycle(1'b0, '0, 1'b1);
      check($sformatf("wr%0d_sdout", i), s_dout, 32'h100 + 32'(i));
      check($sformatf("wr%0d_usedw", i), 32'(s_usedw), 0);
    end
    check("wrap_ov", 32'(f_ov), 0);
    check("wrap_uf", 32'(f_uf), 0);
    check("wrap_s_ov", 32'(s_ov), 0);

    // Flush mid-stream with a concurrent write.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
    check("fl_pre_uf", 32'(f_uf), 1);
    check("fl_pre_usedw", 32'(f_usedw), 3);
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b1);
    check("fl_usedw", 32'(f_usedw), 0);
    check("fl_empty_n", 32'(f_empty_n), 0);
    check("fl_full_n", 32'(f_full_n), 1);
    check("fl_uf", 32'(f_uf), 0);
    check("fl_s_usedw", 32'(s_usedw), 0);
    check("fl_sdout_hold", s_dout, 32'h10B);
    cycle(1'b1, 32'hE0, 1'b0);
    check("fl_fdout_next", f_dout, 32'hE0);
    cycle(1'b0, '0, 1'b1);
    check("fl_sdout_next", s_dout, 32'hE0);

    // Reset mid-stream with a concurrent write.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD0 + 32'(i), 1'b0);
    check("rs_pre_uf", 32'(f_uf), 1);
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0);
    check("rs_usedw", 32'(f_usedw), 0);
    check("rs_empty_n", 32'(f_empty_n), 0);
    check("rs_uf", 32'(f_uf), 0);
    check("rs_fdout", f_dout, 0);
    check("rs_sdout", s_dout, 0);
    cycle(1'b1, 32'hE1, 1'b0);
    check("rs_fdout_next", f_dout, 32'hE1);
    cycle(1'b0, '0, 1'b1);
    check("rs_sdout_next", s_dout, 32'hE1);
    check("rs_final_usedw", 32'(s_usedw), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
